// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU.
// It registers the ALU result and returns it on a tagged valid/ready response channel.
module alu_arbiter #(
  parameter int DATA_W    = 32,
  parameter int OP_W      = 5,
  parameter int PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_control,
  input  logic [DATA_W-1:0] alu_r,
  input  logic              alu_intov,
  output logic              resp_valid,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_r,
  output logic              resp_intov,
  input  logic              resp_ready
);

  // state | meaning
  // IDLE  | output register empty
  // HOLD  | result held in output register until the consumer accepts it
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_last_id;
  logic              r_resp_id;
  logic              r_resp_intov;
  logic [DATA_W-1:0] r_resp_r;
  logic              w_can_issue;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_grant;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_next_state = HOLD;
      HOLD:    if (!w_grant && resp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Nothing is granted while reset is asserted, so no operation is lost across it.
  always_comb begin
    w_can_issue = reset && ((r_state == IDLE) || resp_ready);
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    if (w_can_issue) begin
      if (req0_valid && req1_valid) begin
        if (PRIO_MODE != 0) begin
          w_gnt0 = 1'b1;
        end else begin
          w_gnt0 = r_last_id;
          w_gnt1 = !r_last_id;
        end
      end else begin
        w_gnt0 = req0_valid;
        w_gnt1 = req1_valid;
      end
    end
    w_grant     = w_gnt0 || w_gnt1;
    req0_ready  = w_gnt0;
    req1_ready  = w_gnt1;
    alu_a       = '0;
    alu_b       = '0;
    alu_control = '0;
    if (w_gnt0) begin
      alu_a       = req0_a;
      alu_b       = req0_b;
      alu_control = req0_op;
    end else if (w_gnt1) begin
      alu_a       = req1_a;
      alu_b       = req1_b;
      alu_control = req1_op;
    end
    resp_valid  = (r_state == HOLD);
  end

  // r_last_id resets to 1 so that requester 0 wins the first contested cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_resp_r     <= '0;
      r_resp_intov <= 1'b0;
      r_resp_id    <= 1'b0;
      r_last_id    <= 1'b1;
    end else if (w_grant) begin
      r_resp_r     <= alu_r;
      r_resp_intov <= alu_intov;
      r_resp_id    <= w_gnt1;
      r_last_id    <= w_gnt1;
    end
  end

  assign resp_r     = r_resp_r;
  assign resp_intov = r_resp_intov;
  assign resp_id    = r_resp_id;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: instance 0 is round-robin and instance 1 is fixed priority.
// A behavioural ALU stands in for the external ALU.
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam int OW = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]    v0, v1, rrdy, g0, g1, rv, rid, rov, aov;
  logic [DW-1:0] a0[2], b0[2], a1[2], b1[2], ala[2], alb[2], ar[2], rres[2];
  logic [OW-1:0] op0[2], op1[2], alc[2];

  int checks = 0;
  int errors = 0;

  function automatic logic [DW:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic [OW-1:0] op);
    case (op)
      5'd1:    return {1'b0, a} + {1'b0, b};
      5'd2:    return {1'b0, a} - {1'b0, b};
      5'd3:    return {1'b0, a ^ b};
      default: return {1'b0, a & b};
    endcase
  endfunction

  assign {aov[0], ar[0]} = alu_fn(ala[0], alb[0], alc[0]);
  assign {aov[1], ar[1]} = alu_fn(ala[1], alb[1], alc[1]);

  alu_arbiter #(.DATA_W(DW), .OP_W(OW), .PRIO_MODE(0)) u_rr (
    .clk(clk), .reset(rst_n),
    .req0_valid(v0[0]), .req0_ready(g0[0]), .req0_a(a0[0]), .req0_b(b0[0]), .req0_op(op0[0]),
    .req1_valid(v1[0]), .req1_ready(g1[0]), .req1_a(a1[0]), .req1_b(b1[0]), .req1_op(op1[0]),
    .alu_a(ala[0]), .alu_b(alb[0]), .alu_control(alc[0]), .alu_r(ar[0]), .alu_intov(aov[0]),
    .resp_valid(rv[0]), .resp_id(rid[0]), .resp_r(rres[0]), .resp_intov(rov[0]),
    .resp_ready(rrdy[0]));

  alu_arbiter #(.DATA_W(DW), .OP_W(OW), .PRIO_MODE(1)) u_fp (
    .clk(clk), .reset(rst_n),
    .req0_valid(v0[1]), .req0_ready(g0[1]), .req0_a(a0[1]), .req0_b(b0[1]), .req0_op(op0[1]),
    .req1_valid(v1[1]), .req1_ready(g1[1]), .req1_a(a1[1]), .req1_b(b1[1]), .req1_op(op1[1]),
    .alu_a(ala[1]), .alu_b(alb[1]), .alu_control(alc[1]), .alu_r(ar[1]), .alu_intov(aov[1]),
    .resp_valid(rv[1]), .resp_id(rid[1]), .resp_r(rres[1]), .resp_intov(rov[1]),
    .resp_ready(rrdy[1]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected output state per instance, last winner, queued responses.
  bit            busy[2];
  bit            last[2];
  bit            gx0[2], gx1[2];
  logic [33:0]   q0[$], q1[$];
  bit            rst_applied = 1'b0;

  always @(posedge clk) rst_applied <= !rst_n;

  always @(negedge clk) begin : model
    bit            ci, e0, e1;
    logic [DW:0]   res;
    logic [DW-1:0] ea, eb;
    logic [OW-1:0] eo;
    for (int d = 0; d < 2; d++) begin
      if (rst_applied) begin
        chk($sformatf("rst_resp_valid%0d", d), 64'(rv[d]), 64'(0));
        chk($sformatf("rst_resp_id%0d", d), 64'(rid[d]), 64'(0));
        chk($sformatf("rst_resp_r%0d", d), 64'(rres[d]), 64'(0));
        chk($sformatf("rst_resp_intov%0d", d), 64'(rov[d]), 64'(0));
      end
      if (!rst_n) begin
        chk($sformatf("rst_ready%0d", d), 64'({g1[d], g0[d]}), 64'(0));
        busy[d] = 1'b0;
        last[d] = 1'b1;
        gx0[d]  = 1'b0;
        gx1[d]  = 1'b0;
        if (d == 0) q0.delete(); else q1.delete();
      end else begin
        chk($sformatf("resp_valid%0d", d), 64'(rv[d]), 64'(busy[d]));
        ci = !busy[d] || rrdy[d];
        if (v0[d] && v1[d]) begin
          e0 = (d == 1) ? 1'b1 : (last[d] == 1'b1);
          e1 = !e0;
        end else begin
          e0 = v0[d];
          e1 = v1[d];
        end
        e0 = e0 && ci;
        e1 = e1 && ci;
        chk($sformatf("ready%0d", d), 64'({g1[d], g0[d]}), 64'({e1, e0}));
        ea = e0 ? a0[d] : (e1 ? a1[d] : '0);
        eb = e0 ? b0[d] : (e1 ? b1[d] : '0);
        eo = e0 ? op0[d] : (e1 ? op1[d] : '0);
        chk($sformatf("alu_in%0d", d), {alc[d], ala[d]} ^ (64'(alb[d]) << 5), {eo, ea} ^ (64'(eb) << 5));
        if (e0 || e1) begin
          res = alu_fn(ea, eb, eo);
          if (d == 0) q0.push_back({e1, res}); else q1.push_back({e1, res});
          busy[d] = 1'b1;
          last[d] = e1;
        end else if (busy[d] && rrdy[d]) begin
          busy[d] = 1'b0;
        end
        gx0[d] = e0;
        gx1[d] = e1;
      end
    end
  end

  bit          held[2];
  logic [33:0] held_val[2];

  always @(negedge clk) begin : monitor
    logic [33:0] exp;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        held[d] = 1'b0;
      end else begin
        if (rv[d] && held[d])
          chk($sformatf("resp_stable%0d", d), 64'({rid[d], rov[d], rres[d]}), 64'(held_val[d]));
        if (rv[d] && rrdy[d]) begin
          held[d] = 1'b0;
          if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL resp_unexpected%0d: got id=%0d r=%0h expected no response", d, rid[d], rres[d]);
          end else begin
            exp = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("resp%0d", d), 64'({rid[d], rov[d], rres[d]}), 64'(exp));
          end
        end else if (rv[d]) begin
          held[d]     = 1'b1;
          held_val[d] = {rid[d], rov[d], rres[d]};
        end else begin
          held[d] = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_op(input int d, input int r);
    if (r == 0) begin
      a0[d] = $urandom; b0[d] = $urandom; op0[d] = OW'($urandom_range(0, 3));
    end else begin
      a1[d] = $urandom; b1[d] = $urandom; op1[d] = OW'($urandom_range(0, 3));
    end
  endtask

  task automatic renew(input int d);
    if (gx0[d]) new_op(d, 0);
    if (gx1[d]) new_op(d, 1);
  endtask

  task automatic rand_cycles(input int d, input int n, input int pv);
    repeat (n) begin
      if (!v0[d] || gx0[d]) begin v0[d] = ($urandom_range(0, 99) < pv); new_op(d, 0); end
      if (!v1[d] || gx1[d]) begin v1[d] = ($urandom_range(0, 99) < pv); new_op(d, 1); end
      rrdy[d] = ($urandom_range(0, 3) != 0);
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    v0 = '0; v1 = '0; rrdy = 2'b11;
    for (int d = 0; d < 2; d++) begin new_op(d, 0); new_op(d, 1); end
    // reset held with random inputs
    repeat (2) begin
      v0 = 2'($urandom); v1 = 2'($urandom); rrdy = 2'($urandom);
      for (int d = 0; d < 2; d++) begin new_op(d, 0); new_op(d, 1); end
      tick();
    end
    rst_n = 1'b1; v0 = '0; v1 = '0; rrdy = 2'b11;
    tick();
    // single op 5+3, then a carry-out add from requester 1
    v0[0] = 1'b1; a0[0] = 32'd5; b0[0] = 32'd3; op0[0] = 5'b00001;
    tick();
    v0[0] = 1'b0;
    v1[0] = 1'b1; a1[0] = 32'hFFFF_FFFF; b1[0] = 32'd1; op1[0] = 5'd1;
    tick();
    v1[0] = 1'b0;
    tick();
    // both valid continuously: round-robin alternation
    v0[0] = 1'b1; v1[0] = 1'b1; new_op(0, 0); new_op(0, 1);
    repeat (6) begin tick(); renew(0); end
    // back-pressure in HOLD, then release
    rrdy[0] = 1'b0;
    repeat (3) tick();
    rrdy[0] = 1'b1;
    repeat (2) begin tick(); renew(0); end
    // reset while holding an unaccepted result
    rrdy[0] = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; rrdy[0] = 1'b1;
    repeat (3) begin tick(); renew(0); end
    v0[0] = 1'b0; v1[0] = 1'b0;
    tick();
    // fixed priority: requester 1 waits until requester 0 drops
    v0[1] = 1'b1; v1[1] = 1'b1; rrdy[1] = 1'b1; new_op(1, 0); new_op(1, 1);
    repeat (4) begin tick(); renew(1); end
    v0[1] = 1'b0;
    repeat (2) begin tick(); renew(1); end
    v1[1] = 1'b0;
    tick();
    // randomized traffic on each instance
    rand_cycles(0, 400, 70);
    v0[0] = 1'b0; v1[0] = 1'b0; rrdy[0] = 1'b1;
    rand_cycles(1, 400, 70);
    v0[1] = 1'b0; v1[1] = 1'b1; rrdy[1] = 1'b1;
    v1[1] = 1'b0;
    repeat (4) tick();
    chk("drain_q0", 64'(q0.size()), 64'(0));
    chk("drain_q1", 64'(q1.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
